// File: rtl/bus_seq_pkg.sv
// Shared encodings for the expansion-bus direction sequencer: FSM states,
// the direction-request polarity and the turnaround counter width.
package bus_seq_pkg;

  typedef enum logic [1:0] {
    ST_HIZ   = 2'b00,
    ST_T2D   = 2'b01,
    ST_DRIVE = 2'b10,
    ST_T2H   = 2'b11
  } dir_state_e;

  localparam logic DIR_DRIVE = 1'b0;
  localparam int   TURN_W    = 8;

  // Snapshots are only taken when the bus direction is settled.
  function automatic logic is_settled(input dir_state_e st);
    return (st == ST_HIZ) || (st == ST_DRIVE);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single level signal crossing into the local
// clock domain. The reset value is chosen per use so the idle level is safe.
module sync_bit #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  if (STAGES < 2) begin : g_bad_stages
    $error("sync_bit: STAGES must be at least 2");
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/bus_dir_sequencer.sv
// Direction sequencer for one bidirectional expansion bus: owns the output
// enable, inserts dead-time turnarounds, and captures host-triggered snapshots.
module bus_dir_sequencer
  import bus_seq_pkg::*;
#(
  parameter int BUS_W       = 36,
  parameter int TURN_CYC    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk1,
  input  logic             reset_n,
  input  logic             dir_req,
  input  logic [BUS_W-1:0] drive_data,
  input  logic [BUS_W-1:0] bus_in,
  input  logic             snap_trig,
  output logic             drive_en,
  output logic [BUS_W-1:0] bus_out,
  output logic [BUS_W-1:0] snap_data,
  output logic             snap_valid,
  output logic [15:0]      snap_count,
  output logic             snap_drop,
  output logic             busy,
  output logic [1:0]       dir_state
);

  if (TURN_CYC < 1 || TURN_CYC > 255) begin : g_bad_turn
    $error("bus_dir_sequencer: TURN_CYC must be in 1..255");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("bus_dir_sequencer: SYNC_STAGES must be at least 2");
  end

  localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN_CYC - 1);
  localparam logic [TURN_W-1:0] CNT_ONE   = TURN_W'(1);

  logic              dreq_s;
  dir_state_e        state_q;
  logic [TURN_W-1:0] cnt_q;
  logic              drive_en_q;
  logic              busy_q;
  logic [BUS_W-1:0]  bus_out_q;
  logic [BUS_W-1:0]  bin_q;

  logic              settled;
  logic              capture;
  logic              pending_q,    pending_d;
  logic              snap_drop_q,  snap_drop_d;
  logic [BUS_W-1:0]  snap_data_q,  snap_data_d;
  logic [15:0]       snap_count_q, snap_count_d;
  logic              snap_valid_q;

  // Synchroniser idles at 1 so the bus stays released until the host asks.
  sync_bit #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_dreq_sync (
    .clk_i (clk1),
    .rst_ni(reset_n),
    .d_i   (dir_req),
    .q_o   (dreq_s)
  );

  // ---- direction FSM, turnaround counter and registered enables ----
  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_HIZ;
      cnt_q      <= '0;
      drive_en_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_HIZ: begin
          if (dreq_s == DIR_DRIVE) begin
            state_q <= ST_T2D;
            cnt_q   <= TURN_LOAD;
            busy_q  <= 1'b1;
          end
        end
        ST_T2D: begin
          // Abandoning the turn toward drive is safe: the bus was never driven.
          if (dreq_s != DIR_DRIVE) begin
            state_q <= ST_HIZ;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            state_q    <= ST_DRIVE;
            drive_en_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        ST_DRIVE: begin
          if (dreq_s != DIR_DRIVE) begin
            state_q    <= ST_T2H;
            cnt_q      <= TURN_LOAD;
            drive_en_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_T2H: begin
          // Release turnaround never aborts; a new request is handled from HIZ.
          if (cnt_q == '0) begin
            state_q <= ST_HIZ;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q    <= ST_HIZ;
          cnt_q      <= '0;
          drive_en_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // ---- bus input/output registers ----
  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      bus_out_q <= '0;
      bin_q     <= '0;
    end else begin
      bus_out_q <= drive_data;
      bin_q     <= bus_in;
    end
  end

  // ---- snapshot request / capture next-state ----
  always_comb begin
    settled      = is_settled(state_q);
    capture      = settled && (snap_trig || pending_q);
    pending_d    = pending_q;
    snap_drop_d  = snap_drop_q;
    snap_data_d  = snap_data_q;
    snap_count_d = snap_count_q;

    if (settled) begin
      // A trigger arriving with a completing capture is queued, not dropped.
      pending_d = pending_q && snap_trig;
    end else begin
      pending_d = pending_q || snap_trig;
      if (pending_q && snap_trig) begin
        snap_drop_d = 1'b1;
      end
    end

    if (capture) begin
      snap_data_d  = (state_q == ST_DRIVE) ? bus_out_q : bin_q;
      snap_count_d = snap_count_q + 16'd1;
    end
  end

  // ---- snapshot registers ----
  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      pending_q    <= 1'b0;
      snap_drop_q  <= 1'b0;
      snap_data_q  <= '0;
      snap_count_q <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      snap_drop_q  <= snap_drop_d;
      snap_data_q  <= snap_data_d;
      snap_count_q <= snap_count_d;
      snap_valid_q <= capture;
    end
  end

  assign drive_en   = drive_en_q;
  assign bus_out    = bus_out_q;
  assign snap_data  = snap_data_q;
  assign snap_valid = snap_valid_q;
  assign snap_count = snap_count_q;
  assign snap_drop  = snap_drop_q;
  assign busy       = busy_q;
  assign dir_state  = state_q;

endmodule

// File: tb/tb_bus_dir_sequencer.sv
// Directed self-checking bench for bus_dir_sequencer (BUS_W=36, TURN_CYC=16,
// SYNC_STAGES=2). Inputs change and outputs are sampled on the falling edge.
module tb_bus_dir_sequencer;

  localparam logic [1:0] S_HIZ   = 2'b00;
  localparam logic [1:0] S_T2D   = 2'b01;
  localparam logic [1:0] S_DRIVE = 2'b10;
  localparam logic [1:0] S_T2H   = 2'b11;

  localparam logic [35:0] DRV_VAL  = 36'h1_2345_6789;
  localparam logic [35:0] SNAP_A   = 36'h9_ABCD_1234;
  localparam logic [35:0] SNAP_B   = 36'h5_0F0F_A5A5;

  logic        clk1 = 1'b0;
  logic        reset_n = 1'b0;
  logic        dir_req = 1'b0;
  logic        snap_trig = 1'b0;
  logic [35:0] drive_data = '0;
  logic [35:0] bus_in = '0;

  logic        drive_en;
  logic [35:0] bus_out;
  logic [35:0] snap_data;
  logic        snap_valid;
  logic [15:0] snap_count;
  logic        snap_drop;
  logic        busy;
  logic [1:0]  dir_state;

  int compared = 0;
  int mismatched = 0;
  int rise_at;
  int busy_n;
  int low_n, t2h_n, hiz_n, t2d_n;
  logic en_seen;
  logic [1:0] st_k2, st_k3;

  always #5 clk1 = ~clk1;

  bus_dir_sequencer #(
    .BUS_W      (36),
    .TURN_CYC   (16),
    .SYNC_STAGES(2)
  ) dut (
    .clk1      (clk1),
    .reset_n   (reset_n),
    .dir_req   (dir_req),
    .drive_data(drive_data),
    .bus_in    (bus_in),
    .snap_trig (snap_trig),
    .drive_en  (drive_en),
    .bus_out   (bus_out),
    .snap_data (snap_data),
    .snap_valid(snap_valid),
    .snap_count(snap_count),
    .snap_drop (snap_drop),
    .busy      (busy),
    .dir_state (dir_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] st, input int limit, input string tag);
    int n = 0;
    while (dir_state !== st && n < limit) begin
      @(negedge clk1);
      n++;
    end
    check(tag, 64'(dir_state), 64'(st));
  endtask

  task automatic wait_drive(input int limit, input string tag);
    int n = 0;
    while (drive_en !== 1'b1 && n < limit) begin
      @(negedge clk1);
      n++;
    end
    check(tag, 64'(drive_en), 64'd1);
  endtask

  initial begin
    drive_data = DRV_VAL;
    repeat (3) @(negedge clk1);

    // Reset state
    check("rst_drive_en",   64'(drive_en),   64'd0);
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_state",      64'(dir_state),  64'(S_HIZ));
    check("rst_snap_count", 64'(snap_count), 64'd0);
    check("rst_snap_valid", 64'(snap_valid), 64'd0);
    check("rst_snap_drop",  64'(snap_drop),  64'd0);
    check("rst_snap_data",  64'(snap_data),  64'd0);
    check("rst_bus_out",    64'(bus_out),    64'd0);

    // 1. Power-up toward drive: 2 sync + 1 HIZ decision + 16 turnaround edges
    reset_n = 1'b1;
    rise_at = -1;
    busy_n  = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk1);
      if (busy) busy_n++;
      if (drive_en) begin
        rise_at = k;
        break;
      end
    end
    check("t1_rise_cycle", 64'(rise_at), 64'd19);
    check("t1_busy_cycles", 64'(busy_n), 64'd16);
    check("t1_state_drive", 64'(dir_state), 64'(S_DRIVE));
    check("t1_bus_out", 64'(bus_out), 64'(DRV_VAL));

    // 2. Short release request: full T2H, one HIZ cycle, full T2D
    dir_req = 1'b1;
    repeat (3) @(negedge clk1);
    check("t2_drop_en", 64'(drive_en), 64'd0);
    check("t2_busy", 64'(busy), 64'd1);
    dir_req = 1'b0;
    low_n = 0; t2h_n = 0; hiz_n = 0; t2d_n = 0;
    for (int k = 0; k < 60; k++) begin
      if (drive_en) break;
      low_n++;
      case (dir_state)
        S_T2H:   t2h_n++;
        S_HIZ:   hiz_n++;
        S_T2D:   t2d_n++;
        default: ;
      endcase
      @(negedge clk1);
    end
    check("t2_low_cycles", 64'(low_n), 64'd33);
    check("t2_t2h_cycles", 64'(t2h_n), 64'd16);
    check("t2_hiz_cycles", 64'(hiz_n), 64'd1);
    check("t2_t2d_cycles", 64'(t2d_n), 64'd16);

    // 3. Abort T2D at count 5
    dir_req = 1'b1;
    wait_state(S_HIZ, 40, "t3_reach_hiz");
    dir_req = 1'b0;
    wait_state(S_T2D, 10, "t3_reach_t2d");
    repeat (10) @(negedge clk1);
    dir_req = 1'b1;
    en_seen = 1'b0;
    st_k2 = 2'bxx;
    st_k3 = 2'bxx;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk1);
      if (drive_en) en_seen = 1'b1;
      if (k == 2) st_k2 = dir_state;
      if (k == 3) st_k3 = dir_state;
    end
    check("t3_state_k2", 64'(st_k2), 64'(S_T2D));
    check("t3_state_k3", 64'(st_k3), 64'(S_HIZ));
    check("t3_no_drive", 64'(en_seen), 64'd0);
    check("t3_busy_low", 64'(busy), 64'd0);

    // 4. Snapshot in HIZ
    bus_in = SNAP_A;
    @(negedge clk1);
    snap_trig = 1'b1;
    @(negedge clk1);
    snap_trig = 1'b0;
    check("t4_snap_data", 64'(snap_data), 64'(SNAP_A));
    check("t4_snap_valid", 64'(snap_valid), 64'd1);
    check("t4_snap_count", 64'(snap_count), 64'd1);
    @(negedge clk1);
    check("t4_valid_pulse", 64'(snap_valid), 64'd0);
    check("t4_no_drop", 64'(snap_drop), 64'd0);

    // 4b. Snapshot in DRIVE takes the driven value
    dir_req = 1'b0;
    wait_drive(40, "t4b_reach_drive");
    snap_trig = 1'b1;
    @(negedge clk1);
    snap_trig = 1'b0;
    check("t4b_snap_data", 64'(snap_data), 64'(DRV_VAL));
    check("t4b_snap_count", 64'(snap_count), 64'd2);

    // 5. Two triggers during T2H: one deferred capture, sticky drop
    bus_in  = SNAP_B;
    dir_req = 1'b1;
    wait_state(S_T2H, 10, "t5_reach_t2h");
    snap_trig = 1'b1;
    @(negedge clk1);
    snap_trig = 1'b0;
    @(negedge clk1);
    snap_trig = 1'b1;
    @(negedge clk1);
    snap_trig = 1'b0;
    check("t5_drop", 64'(snap_drop), 64'd1);
    check("t5_deferred_valid", 64'(snap_valid), 64'd0);
    check("t5_deferred_count", 64'(snap_count), 64'd2);
    wait_state(S_HIZ, 30, "t5_reach_hiz");
    check("t5_hiz_first_valid", 64'(snap_valid), 64'd0);
    @(negedge clk1);
    check("t5_cap_valid", 64'(snap_valid), 64'd1);
    check("t5_cap_data", 64'(snap_data), 64'(SNAP_B));
    check("t5_cap_count", 64'(snap_count), 64'd3);
    @(negedge clk1);
    check("t5_single_capture", 64'(snap_count), 64'd3);
    check("t5_drop_sticky", 64'(snap_drop), 64'd1);

    // 6. Counter wrap from 0xFFFF
    force dut.snap_count_q = 16'hFFFF;
    snap_trig = 1'b1;
    #1;
    release dut.snap_count_q;
    @(negedge clk1);
    snap_trig = 1'b0;
    check("t6_wrap_count", 64'(snap_count), 64'd0);
    check("t6_wrap_valid", 64'(snap_valid), 64'd1);

    // 6b. Asynchronous reset mid-DRIVE
    dir_req = 1'b0;
    wait_drive(40, "t6b_reach_drive");
    #2;
    reset_n = 1'b0;
    #1;
    check("t6b_async_drive_en", 64'(drive_en), 64'd0);
    check("t6b_async_state", 64'(dir_state), 64'(S_HIZ));
    check("t6b_async_busy", 64'(busy), 64'd0);
    check("t6b_async_drop", 64'(snap_drop), 64'd0);
    check("t6b_async_data", 64'(snap_data), 64'd0);
    check("t6b_async_bus_out", 64'(bus_out), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
